// File: rtl/noc_out_port.sv
// noc_out_port: output-port stage of a NOC router.
// It generates a rotating one-hot grant token (turn) for the route logic and
// accepts the selected input flit into a small circular FIFO. Flits are then
// launched onto the link under a credit counter that the downstream router
// refills with credit_inc_i.
// Optional feature macro: NOC_OUTPORT_BYPASS_EN. When it is defined, a legal
// push into an empty FIFO with credit available goes straight to data_o in the
// same edge, giving a 1-cycle latency.
// err_o is sticky until reset. It flags a push while full, an illegal
// port_select, and a credit return while the counter is already at CREDITS.

module noc_out_port #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] N_data_i,
  input  logic [7:0] S_data_i,
  input  logic [7:0] E_data_i,
  input  logic [7:0] W_data_i,
  input  logic [7:0] L_data_i,
  input  logic [2:0] port_select,
  input  logic       port_enable,
  output logic       port_full,
  output logic [4:0] turn,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       credit_inc_i,
  output logic       err_o
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CW   = $clog2(CREDITS + 1);

  localparam logic [CNTW-1:0] DEPTH_C    = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_ZERO   = CNTW'(0);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [CW-1:0]   CREDITS_C  = CW'(CREDITS);
  localparam logic [CW-1:0]   CRED_ZERO  = CW'(0);
  localparam logic [CW-1:0]   CRED_ONE   = CW'(1);
  localparam logic [AW-1:0]   PTR_ZERO   = AW'(0);
  localparam logic [AW-1:0]   PTR_ONE    = AW'(1);

  // Registered state
  logic [4:0]      turn_r;
  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            full_r;
  logic [CW-1:0]   credit_r;
  logic [7:0]      data_r;
  logic            valid_r;
  logic            err_r;

  // Combinational decode
  logic [7:0]      sel_data_s;
  logic            sel_ok_s;
  logic            push_ok_s;
  logic            fifo_empty_s;
  logic            credit_ok_s;
  logic            launch_s;
  logic            bypass_s;
  logic            fifo_push_s;
  logic            send_s;
  logic            credit_ovf_s;
  logic            err_set_s;
  logic [CW-1:0]   credit_nxt_s;
  logic [CNTW-1:0] count_nxt_s;

  assign turn      = turn_r;
  assign port_full = full_r;
  assign data_o    = data_r;
  assign valid_o   = valid_r;
  assign err_o     = err_r;

  // Source multiplexer: pick the head flit of the selected input buffer
  always_comb begin
    sel_data_s = 8'h00;
    case (port_select)
      3'd0:    sel_data_s = N_data_i;
      3'd1:    sel_data_s = S_data_i;
      3'd2:    sel_data_s = E_data_i;
      3'd3:    sel_data_s = W_data_i;
      3'd4:    sel_data_s = L_data_i;
      default: sel_data_s = 8'h00;
    endcase
  end

  assign sel_ok_s     = (port_select <= 3'd4);
  assign push_ok_s    = port_enable & ~full_r & sel_ok_s;
  assign fifo_empty_s = (count_r == CNT_ZERO);
  assign credit_ok_s  = (credit_r != CRED_ZERO);
  assign launch_s     = ~fifo_empty_s & credit_ok_s;

`ifdef NOC_OUTPORT_BYPASS_EN
  assign bypass_s     = push_ok_s & fifo_empty_s & credit_ok_s;
`else
  assign bypass_s     = 1'b0;
`endif

  assign fifo_push_s  = push_ok_s & ~bypass_s;
  assign send_s       = launch_s | bypass_s;
  assign credit_ovf_s = credit_inc_i & ~send_s & (credit_r == CREDITS_C);
  assign err_set_s    = (port_enable & (full_r | ~sel_ok_s)) | credit_ovf_s;

  // Credit next-state: minus one per send, plus one per returned credit, saturating at CREDITS
  always_comb begin
    credit_nxt_s = credit_r;
    case ({send_s, credit_inc_i})
      2'b10: credit_nxt_s = credit_r - CRED_ONE;
      2'b01: begin
        if (credit_ovf_s) begin
          credit_nxt_s = credit_r;
        end else begin
          credit_nxt_s = credit_r + CRED_ONE;
        end
      end
      default: credit_nxt_s = credit_r;
    endcase
  end

  // FIFO occupancy next-state: a push and a pop together leave the count unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({fifo_push_s, launch_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Grant token: unconditional right rotate, bit 0 wraps to bit 4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turn_r <= 5'b10000;
    end else begin
      turn_r <= {turn_r[0], turn_r[4:1]};
    end
  end

  // FIFO storage: write the selected flit at the write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (fifo_push_s) begin
      mem_r[wr_ptr_r] <= sel_data_s;
    end
  end

  // FIFO pointers, count and registered full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
    end else begin
      if (fifo_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (launch_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
    end
  end

  // Credit counter towards the downstream input buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r <= CREDITS_C;
    end else begin
      credit_r <= credit_nxt_s;
    end
  end

  // Link output: load the head (or bypassed) flit on a send, otherwise hold data and drop valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
    end else if (send_s) begin
      data_r  <= bypass_s ? sel_data_s : mem_r[rd_ptr_r];
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  // Sticky protocol-error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_out_port.sv
// Self-checking bench for noc_out_port (DEPTH = 4, CREDITS = 4).
// Expected flits are queued when a legal push is driven. A negedge monitor
// pops them and compares whenever valid_o is high.

module tb_noc_out_port;

  logic       clk;
  logic       rst_n;
  logic [7:0] N_data_i, S_data_i, E_data_i, W_data_i, L_data_i;
  logic [2:0] port_select;
  logic       port_enable;
  logic       port_full;
  logic [4:0] turn;
  logic [7:0] data_o;
  logic       valid_o;
  logic       credit_inc_i;
  logic       err_o;

  int         total;
  int         bad;
  int         vcnt;
  int         v0;
  logic [7:0] exp_q [$];
  logic [4:0] turn_tab [5];

  noc_out_port #(.DEPTH(4), .CREDITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .N_data_i     (N_data_i),
    .S_data_i     (S_data_i),
    .E_data_i     (E_data_i),
    .W_data_i     (W_data_i),
    .L_data_i     (L_data_i),
    .port_select  (port_select),
    .port_enable  (port_enable),
    .port_full    (port_full),
    .turn         (turn),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .credit_inc_i (credit_inc_i),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive distinct filler on every source, then the wanted value on one
  task automatic drive_src(input logic [2:0] s, input logic [7:0] d);
    N_data_i = 8'hA0;
    S_data_i = 8'hA1;
    E_data_i = 8'hA2;
    W_data_i = 8'hA3;
    L_data_i = 8'hA4;
    case (s)
      3'd0:    N_data_i = d;
      3'd1:    S_data_i = d;
      3'd2:    E_data_i = d;
      3'd3:    W_data_i = d;
      default: L_data_i = d;
    endcase
    port_select = s;
  endtask

  task automatic push_flit(input logic [2:0] s, input logic [7:0] d);
    drive_src(s, d);
    port_enable = 1'b1;
    exp_q.push_back(d);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    port_enable = 1'b0;
    credit_inc_i = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every valid cycle carries exactly one expected flit
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1) begin
      vcnt++;
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk_eq("sb_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    bit done;
    total = 0;
    bad = 0;
    vcnt = 0;
    turn_tab[0] = 5'b01000;
    turn_tab[1] = 5'b00100;
    turn_tab[2] = 5'b00010;
    turn_tab[3] = 5'b00001;
    turn_tab[4] = 5'b10000;
    rst_n = 1'b0;
    port_enable = 1'b0;
    credit_inc_i = 1'b0;
    drive_src(3'd0, 8'h00);

    // Reset values and turn rotation
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_turn", {27'd0, turn}, 32'h10);
    chk_eq("rst_valid", {31'd0, valid_o}, 32'd0);
    chk_eq("rst_err", {31'd0, err_o}, 32'd0);
    chk_eq("rst_full", {31'd0, port_full}, 32'd0);
    chk_eq("rst_data", {24'd0, data_o}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq("turn_rot", {27'd0, turn}, {27'd0, turn_tab[i]});
    end

    // Single flit from E
    v0 = vcnt;
    drive_src(3'd2, 8'h21);
    port_enable = 1'b1;
    exp_q.push_back(8'h21);
    tick();
    port_enable = 1'b0;
`ifdef NOC_OUTPORT_BYPASS_EN
    chk_eq("single_valid1", {31'd0, valid_o}, 32'd1);
    chk_eq("single_data", {24'd0, data_o}, 32'h21);
    tick();
    chk_eq("single_valid0", {31'd0, valid_o}, 32'd0);
`else
    chk_eq("single_lat_early", {31'd0, valid_o}, 32'd0);
    tick();
    chk_eq("single_valid1", {31'd0, valid_o}, 32'd1);
    chk_eq("single_data", {24'd0, data_o}, 32'h21);
    tick();
    chk_eq("single_valid0", {31'd0, valid_o}, 32'd0);
    chk_eq("single_hold", {24'd0, data_o}, 32'h21);
`endif
    chk_eq("single_count", vcnt - v0, 32'd1);
    // return the used credit; counter 3 -> 4 is legal
    credit_inc_i = 1'b1;
    tick();
    credit_inc_i = 1'b0;
    chk_eq("single_err", {31'd0, err_o}, 32'd0);

    // Wrap-around: 20 flits, credit returned one cycle after each valid
    v0 = vcnt;
    sent = 0;
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      port_enable = (sent < 20) && !port_full;
      if (port_enable) begin
        drive_src(3'(sent % 5), sent[7:0]);
        exp_q.push_back(sent[7:0]);
        sent++;
      end
      credit_inc_i = valid_o;
      tick();
      cyc++;
      if (sent == 20 && exp_q.size() == 0 && !valid_o) done = 1'b1;
      if (cyc >= 200) begin
        chk_eq("wrap_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    port_enable = 1'b0;
    credit_inc_i = 1'b0;
    chk_eq("wrap_count", vcnt - v0, 32'd20);
    chk_eq("wrap_err", {31'd0, err_o}, 32'd0);

    // Simultaneous launch and credit return at credit 1, count 2
    for (int i = 0; i < 6; i++) begin
      push_flit(3'(i % 5), 8'(8'h30 + i));
    end
    port_enable = 1'b0;
    credit_inc_i = 1'b1;
    tick();
    chk_eq("simul_idle", {31'd0, valid_o}, 32'd0);
    tick();
    credit_inc_i = 1'b0;
    chk_eq("simul_first", {31'd0, valid_o}, 32'd1);
    tick();
    chk_eq("simul_second", {31'd0, valid_o}, 32'd1);
    tick();
    chk_eq("simul_done", {31'd0, valid_o}, 32'd0);
    chk_eq("simul_q", exp_q.size(), 32'd0);

    // Credit now 0: a pushed flit stays in the FIFO
    push_flit(3'd1, 8'h77);
    port_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("nocredit_stall", {31'd0, valid_o}, 32'd0);
    end

    // Asynchronous reset mid-operation discards FIFO and credits
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk_eq("async_turn", {27'd0, turn}, 32'h10);
    chk_eq("async_full", {31'd0, port_full}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = vcnt;
    repeat (4) tick();
    chk_eq("async_discard", vcnt - v0, 32'd0);

    // Credit stall: 8 pushes, 4 credits, no returns
    v0 = vcnt;
    for (int i = 1; i <= 8; i++) begin
      push_flit(3'(i % 5), 8'(i));
    end
    port_enable = 1'b0;
    tick();
    tick();
    chk_eq("stall_launched", vcnt - v0, 32'd4);
    chk_eq("stall_full", {31'd0, port_full}, 32'd1);
    chk_eq("stall_err0", {31'd0, err_o}, 32'd0);
    chk_eq("stall_q", exp_q.size(), 32'd4);
    drive_src(3'd0, 8'hEE);
    port_enable = 1'b1;
    tick();
    port_enable = 1'b0;
    chk_eq("full_push_err", {31'd0, err_o}, 32'd1);
    chk_eq("full_still", {31'd0, port_full}, 32'd1);
    credit_inc_i = 1'b1;
    tick();
    credit_inc_i = 1'b0;
    chk_eq("resume_early", {31'd0, valid_o}, 32'd0);
    tick();
    chk_eq("resume_valid", {31'd0, valid_o}, 32'd1);
    chk_eq("resume_data", {24'd0, data_o}, 32'h05);
    tick();
    chk_eq("resume_single", {31'd0, valid_o}, 32'd0);
    chk_eq("resume_notfull", {31'd0, port_full}, 32'd0);
    credit_inc_i = 1'b1;
    repeat (3) tick();
    credit_inc_i = 1'b0;
    repeat (3) tick();
    chk_eq("drain_q", exp_q.size(), 32'd0);

    // Illegal port_select
    do_reset();
    v0 = vcnt;
    drive_src(3'd4, 8'h5A);
    port_select = 3'd7;
    port_enable = 1'b1;
    tick();
    port_enable = 1'b0;
    chk_eq("badsel_err", {31'd0, err_o}, 32'd1);
    repeat (3) tick();
    chk_eq("badsel_novalid", vcnt - v0, 32'd0);

    // Credit return at full credit: error, counter saturates
    do_reset();
    chk_eq("ovf_err_pre", {31'd0, err_o}, 32'd0);
    credit_inc_i = 1'b1;
    tick();
    credit_inc_i = 1'b0;
    chk_eq("ovf_err", {31'd0, err_o}, 32'd1);
    v0 = vcnt;
    for (int i = 0; i < 5; i++) begin
      push_flit(3'd3, 8'(8'h60 + i));
    end
    port_enable = 1'b0;
    repeat (6) tick();
    chk_eq("ovf_saturated", vcnt - v0, 32'd4);
    chk_eq("ovf_q", exp_q.size(), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
